// File: rtl/ucsbece154b_issue_scheduler.sv
// ucsbece154b_issue_scheduler
//   In-order dual-issue scheduler sitting between fetch and the two decode
//   slots. Fetched instructions are buffered in a DEPTH-entry circular FIFO;
//   each cycle the one or two oldest entries are moved into the registered
//   decode slots. Slot 1 always carries the older instruction. Pairing is
//   refused when the head is control flow, when the pair has a RAW or WAW
//   register hazard, or when both are memory ops (single D-mem port).
//   Also counts single- and dual-issue cycles (saturating).
//
// Handshake: fetch presents FetchValidF_i (bit0 = InstrF_i, bit1 = InstrF2_i,
//   bit1 implies bit0); entries are accepted on a clock edge only when
//   FetchReady_o is high at that edge, otherwise the fetch is ignored and must
//   be re-presented. FetchReady_o depends only on the registered fill level.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   FetchValidF_i[1:0]         fetch-side valid per instruction
//   InstrF_i, InstrF2_i        older / younger fetched instruction
//   PCF_i                      PC of InstrF_i (InstrF2_i is at PCF_i+4)
//   FetchReady_o               at least two free FIFO entries
//   StallD_i                   hold decode slots and FIFO head
//   Flush_i                    discard FIFO contents and decode slots
//   InstrD_o/PCD_o             slot-1 instruction and PC
//   InstrD2_o/PCD2_o           slot-2 instruction and PC
//   IssueValidD_o/_D2_o        slot valids
//   SingleIssueCount_o         cycles that issued exactly one instruction
//   DualIssueCount_o           cycles that issued two instructions
module ucsbece154b_issue_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       FetchValidF_i,
  input  logic [31:0]      InstrF_i,
  input  logic [31:0]      InstrF2_i,
  input  logic [31:0]      PCF_i,
  output logic             FetchReady_o,
  input  logic             StallD_i,
  input  logic             Flush_i,
  output logic [31:0]      InstrD_o,
  output logic [31:0]      InstrD2_o,
  output logic [31:0]      PCD_o,
  output logic [31:0]      PCD2_o,
  output logic             IssueValidD_o,
  output logic             IssueValidD2_o,
  output logic [CNT_W-1:0] SingleIssueCount_o,
  output logic [CNT_W-1:0] DualIssueCount_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic writesRd(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_RTYPE) || (op == OP_ITYPE) ||
           (op == OP_JAL)  || (op == OP_JALR)  || (op == OP_LUI);
  endfunction

  function automatic logic readsRs1(input logic [6:0] op);
    return !((op == OP_JAL) || (op == OP_LUI));
  endfunction

  function automatic logic readsRs2(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic isMem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic isCtrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  logic [31:0] instrQ [DEPTH];
  logic [31:0] pcQ    [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic [PW-1:0] headP1, tailP1;
  logic [31:0]   h0Instr, h1Instr, h0Pc, h1Pc;
  logic [6:0]    op0, op1;
  logic [4:0]    rd0, rd1, rs1H1, rs2H1;
  logic          rawHaz, wawHaz, memPair, refusePair;
  logic          enq;
  logic [PW:0]   enqCnt, deqCnt;
  logic [1:0]    issueN;

  assign headP1 = head + 1'b1;
  assign tailP1 = tail + 1'b1;

  assign h0Instr = instrQ[head];
  assign h1Instr = instrQ[headP1];
  assign h0Pc    = pcQ[head];
  assign h1Pc    = pcQ[headP1];

  assign op0   = h0Instr[6:0];
  assign op1   = h1Instr[6:0];
  assign rd0   = h0Instr[11:7];
  assign rd1   = h1Instr[11:7];
  assign rs1H1 = h1Instr[19:15];
  assign rs2H1 = h1Instr[24:20];

  // Hazards only matter when H0 actually produces a non-x0 result.
  assign rawHaz = writesRd(op0) && (rd0 != 5'd0) &&
                  ((readsRs1(op1) && (rs1H1 == rd0)) ||
                   (readsRs2(op1) && (rs2H1 == rd0)));
  assign wawHaz = writesRd(op0) && writesRd(op1) && (rd0 != 5'd0) && (rd0 == rd1);
  assign memPair = isMem(op0) && isMem(op1);
  assign refusePair = isCtrl(op0) || rawHaz || wawHaz || memPair;

  assign FetchReady_o = (32'(count) <= DEPTH - 2);

  assign enq    = FetchReady_o && (FetchValidF_i != 2'b00) && !Flush_i;
  assign enqCnt = !enq ? '0 : (FetchValidF_i[1] ? (PW+1)'(2) : (PW+1)'(1));
  assign deqCnt = (PW+1)'(issueN);

  // Number of head entries moved to decode this edge. Decided purely from
  // registered FIFO state, so a freshly written entry waits one edge.
  always_comb begin
    issueN = 2'd0;
    if (!StallD_i && !Flush_i) begin
      if (count == '0)
        issueN = 2'd0;
      else if ((count == (PW+1)'(1)) || refusePair)
        issueN = 2'd1;
      else
        issueN = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      InstrD_o           <= NOP;
      InstrD2_o          <= NOP;
      PCD_o              <= '0;
      PCD2_o             <= '0;
      IssueValidD_o      <= 1'b0;
      IssueValidD2_o     <= 1'b0;
      SingleIssueCount_o <= '0;
      DualIssueCount_o   <= '0;
    end else if (Flush_i) begin
      // Flush wins over stall and drops any same-cycle fetch; counters keep history.
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      InstrD_o       <= NOP;
      InstrD2_o      <= NOP;
      PCD_o          <= '0;
      PCD2_o         <= '0;
      IssueValidD_o  <= 1'b0;
      IssueValidD2_o <= 1'b0;
    end else begin
      if (enq) begin
        instrQ[tail] <= InstrF_i;
        pcQ[tail]    <= PCF_i;
        if (FetchValidF_i[1]) begin
          instrQ[tailP1] <= InstrF2_i;
          pcQ[tailP1]    <= PCF_i + 32'd4;
        end
        tail <= tail + PW'(enqCnt);
      end

      if (!StallD_i) begin
        IssueValidD_o  <= (issueN != 2'd0);
        IssueValidD2_o <= (issueN == 2'd2);
        InstrD_o       <= (issueN != 2'd0) ? h0Instr : NOP;
        PCD_o          <= (issueN != 2'd0) ? h0Pc    : 32'd0;
        InstrD2_o      <= (issueN == 2'd2) ? h1Instr : NOP;
        PCD2_o         <= (issueN == 2'd2) ? h1Pc    : 32'd0;
        head           <= head + PW'(issueN);
        if ((issueN == 2'd1) && (SingleIssueCount_o != '1))
          SingleIssueCount_o <= SingleIssueCount_o + 1'b1;
        if ((issueN == 2'd2) && (DualIssueCount_o != '1))
          DualIssueCount_o <= DualIssueCount_o + 1'b1;
      end

      count <= count + enqCnt - deqCnt;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_issue_scheduler.sv
module tb_ucsbece154b_issue_scheduler;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD1  = 32'h003100B3; // add  x1,x2,x3
  localparam logic [31:0] ADD4  = 32'h00628233; // add  x4,x5,x6
  localparam logic [31:0] ADDI5 = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] ADD6  = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] LW1   = 32'h00012083; // lw   x1,0(x2)
  localparam logic [31:0] SW3   = 32'h00322223; // sw   x3,4(x4)
  localparam logic [31:0] BEQ   = 32'h00208063; // beq  x1,x2,0
  localparam logic [31:0] BAD1  = 32'h009403B3; // add  x7,x8,x9   (must never issue)
  localparam logic [31:0] BAD2  = 32'h00C58533; // add  x10,x11,x12 (must never issue)

  localparam int W = 129; // {v2, instr1, pc1, instr2, pc2}

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  FetchValidF_i;
  logic [31:0] InstrF_i, InstrF2_i, PCF_i;
  logic        FetchReady_o;
  logic        StallD_i, Flush_i;
  logic [31:0] InstrD_o, InstrD2_o, PCD_o, PCD2_o;
  logic        IssueValidD_o, IssueValidD2_o;
  logic [31:0] SingleIssueCount_o, DualIssueCount_o;

  ucsbece154b_issue_scheduler #(.DEPTH(4), .CNT_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .FetchValidF_i      (FetchValidF_i),
    .InstrF_i           (InstrF_i),
    .InstrF2_i          (InstrF2_i),
    .PCF_i              (PCF_i),
    .FetchReady_o       (FetchReady_o),
    .StallD_i           (StallD_i),
    .Flush_i            (Flush_i),
    .InstrD_o           (InstrD_o),
    .InstrD2_o          (InstrD2_o),
    .PCD_o              (PCD_o),
    .PCD2_o             (PCD2_o),
    .IssueValidD_o      (IssueValidD_o),
    .IssueValidD2_o     (IssueValidD2_o),
    .SingleIssueCount_o (SingleIssueCount_o),
    .DualIssueCount_o   (DualIssueCount_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    FetchValidF_i = v;
    InstrF_i      = a;
    InstrF2_i     = b;
    PCF_i         = pc;
    step(1);
    FetchValidF_i = 2'b00;
  endtask

  task automatic exp_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    exp_q.push_back({1'b1, a, pc, b, pc + 32'd4});
  endtask

  task automatic exp_single(input logic [31:0] a, input logic [31:0] pc);
    exp_q.push_back({1'b0, a, pc, NOP, 32'd0});
  endtask

  // ---------------- scoreboard monitor ----------------
  // An edge advances decode when it was not in reset, stall or flush.
  bit advanced = 1'b0;
  always @(posedge clk) advanced = !reset && !StallD_i && !Flush_i;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (advanced && (IssueValidD_o || IssueValidD2_o)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got instr %h pc %h v2 %0b, required no issue",
                 InstrD_o, PCD_o, IssueValidD2_o);
      end else begin
        e = exp_q.pop_front();
        if (!IssueValidD_o || (IssueValidD2_o !== e[128]) ||
            (InstrD_o !== e[127:96]) || (PCD_o !== e[95:64]) ||
            (InstrD2_o !== e[63:32]) || (e[128] && (PCD2_o !== e[31:0]))) begin
          miscompares++;
          $display("FAIL issue_packet: got v=%0b%0b i1=%h p1=%h i2=%h p2=%h required v=1%0b i1=%h p1=%h i2=%h p2=%h",
                   IssueValidD_o, IssueValidD2_o, InstrD_o, PCD_o, InstrD2_o, PCD2_o,
                   e[128], e[127:96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    FetchValidF_i = 2'b00;
    InstrF_i = '0;
    InstrF2_i = '0;
    PCF_i = '0;
    StallD_i = 1'b0;
    Flush_i = 1'b0;

    // Reset values
    step(2);
    check("rst_valid1", 32'(IssueValidD_o), 32'd0);
    check("rst_valid2", 32'(IssueValidD2_o), 32'd0);
    check("rst_instr1", InstrD_o, NOP);
    check("rst_instr2", InstrD2_o, NOP);
    check("rst_ready", 32'(FetchReady_o), 32'd1);
    check("rst_single", SingleIssueCount_o, 32'd0);
    check("rst_dual", DualIssueCount_o, 32'd0);
    reset = 1'b0;

    // Independent pair dual-issues one edge after the write
    exp_pair(ADD1, ADD4, 32'h100);
    fetch(2'b11, ADD1, ADD4, 32'h100);
    check("no_bypass_valid", 32'(IssueValidD_o), 32'd0);
    step(1);
    check("pair_pcd2", PCD2_o, 32'h104);
    check("pair_dual", DualIssueCount_o, 32'd1);
    check("pair_single", SingleIssueCount_o, 32'd0);

    // RAW hazard splits the pair
    exp_single(ADDI5, 32'h200);
    exp_single(ADD6, 32'h204);
    fetch(2'b11, ADDI5, ADD6, 32'h200);
    step(2);
    check("raw_single", SingleIssueCount_o, 32'd2);

    // Two memory ops split, then a branch head blocks pairing
    exp_single(LW1, 32'h300);
    exp_single(SW3, 32'h304);
    fetch(2'b11, LW1, SW3, 32'h300);
    step(1);
    check("mem_slot2_valid", 32'(IssueValidD2_o), 32'd0);
    step(1);
    check("mem_second", InstrD_o, SW3);
    exp_single(BEQ, 32'h400);
    exp_single(ADD4, 32'h404);
    fetch(2'b11, BEQ, ADD4, 32'h400);
    step(1);
    check("beq_slot2_valid", 32'(IssueValidD2_o), 32'd0);
    check("beq_slot2_instr", InstrD2_o, NOP);
    step(1);
    // Single-entry fetch moves tail off zero so the next fill wraps
    exp_single(ADDI5, 32'h480);
    fetch(2'b01, ADDI5, 32'h0, 32'h480);
    step(1);
    check("single_total", SingleIssueCount_o, 32'd7);

    // Stall: fill to four entries, outputs frozen, full FIFO ignores fetch
    StallD_i = 1'b1;
    exp_pair(ADD1, ADD4, 32'h500);
    exp_pair(LW1, ADD4, 32'h508);
    fetch(2'b11, ADD1, ADD4, 32'h500);
    check("stall_ready_half", 32'(FetchReady_o), 32'd1);
    fetch(2'b11, LW1, ADD4, 32'h508);
    check("stall_ready_full", 32'(FetchReady_o), 32'd0);
    fetch(2'b11, BAD1, BAD2, 32'h5F0);
    check("stall_hold_instr", InstrD_o, ADDI5);
    check("stall_hold_pc", PCD_o, 32'h480);
    check("stall_hold_valid", 32'(IssueValidD_o), 32'd1);
    check("stall_single", SingleIssueCount_o, 32'd7);
    check("stall_dual", DualIssueCount_o, 32'd1);
    StallD_i = 1'b0;
    step(1);
    check("drain_ready", 32'(FetchReady_o), 32'd1);
    step(1);
    check("drain_dual", DualIssueCount_o, 32'd3);
    step(1);
    check("drain_empty_valid", 32'(IssueValidD_o), 32'd0);

    // Flush with three entries queued, stall asserted and fetch presented
    StallD_i = 1'b1;
    fetch(2'b11, BAD1, BAD2, 32'h700);
    fetch(2'b01, BAD1, 32'h0, 32'h708);
    check("pre_flush_ready", 32'(FetchReady_o), 32'd0);
    Flush_i = 1'b1;
    fetch(2'b11, BAD2, BAD1, 32'h710);
    Flush_i = 1'b0;
    StallD_i = 1'b0;
    check("flush_valid1", 32'(IssueValidD_o), 32'd0);
    check("flush_valid2", 32'(IssueValidD2_o), 32'd0);
    check("flush_instr1", InstrD_o, NOP);
    check("flush_instr2", InstrD2_o, NOP);
    check("flush_ready", 32'(FetchReady_o), 32'd1);
    step(3);

    // Flush on an empty FIFO drops the same-cycle fetch
    Flush_i = 1'b1;
    fetch(2'b11, BAD1, BAD2, 32'h720);
    Flush_i = 1'b0;
    step(3);
    check("flush_single_kept", SingleIssueCount_o, 32'd7);
    check("flush_dual_kept", DualIssueCount_o, 32'd3);

    // FIFO restarts cleanly after flush
    exp_pair(ADD1, ADD4, 32'h600);
    fetch(2'b11, ADD1, ADD4, 32'h600);
    step(1);
    check("post_flush_dual", DualIssueCount_o, 32'd4);
    step(2);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound on total runtime
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
